sram_req_adapter: RTL and testbench



---
 rtl/sram22_pkg.sv | 20 ++
 rtl/sram_rsp_fifo.sv | 68 ++++++
 rtl/sram_req_adapter.sv | 109 ++++++++++
 tb/tb_sram_req_adapter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram22_pkg.sv
// Shared types and geometry for the SRAM22 64x32 macro with an 8-bit-lane write mask.
package sram22_pkg;

  localparam int SRAM_DATA_WIDTH  = 32;
  localparam int SRAM_ADDR_WIDTH  = 6;
  localparam int SRAM_WMASK_WIDTH = 4;

  typedef struct packed {
    logic                        we;
    logic [SRAM_WMASK_WIDTH-1:0] wmask;
    logic [SRAM_ADDR_WIDTH-1:0]  addr;
    logic [SRAM_DATA_WIDTH-1:0]  wdata;
  } sram_req_t;

  typedef struct packed {
    logic                       is_wr;
    logic [SRAM_DATA_WIDTH-1:0] rdata;
  } sram_rsp_t;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Small synchronous FIFO with occupancy count; pointers wrap modulo DEPTH.
module sram_rsp_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 2,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty  = (count_q == '0);
  assign full   = (count_q == CW'(DEPTH));
  assign do_pop = pop & ~empty;
  assign rdata  = mem_q[rptr_q];
  assign count  = count_q;

  always_comb begin
    wptr_d  = push   ? ptr_inc(wptr_q) : wptr_q;
    rptr_d  = do_pop ? ptr_inc(rptr_q) : rptr_q;
    count_d = count_q;
    case ({push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; validity is tracked entirely by count_q.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(push && full && !pop));
      assert (!(pop && empty));
    end
  end

endmodule

// File: rtl/sram_req_adapter.sv
// Valid/ready front-end for one SRAM22 macro with a credit-limited, in-order response path.
// Optional SRAM_REQ_ADAPTER_WRITE_ACK_EN: every accepted write also returns an is_wr beat.
module sram_req_adapter
  import sram22_pkg::*;
#(
  parameter int DATA_WIDTH  = SRAM_DATA_WIDTH,
  parameter int ADDR_WIDTH  = SRAM_ADDR_WIDTH,
  parameter int WMASK_WIDTH = SRAM_WMASK_WIDTH,
  parameter int RSP_DEPTH   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [WMASK_WIDTH-1:0] req_wmask,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [DATA_WIDTH-1:0]  req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_WIDTH-1:0]  rsp_rdata,
  output logic                   rsp_is_wr,
  output logic                   sram_we,
  output logic [WMASK_WIDTH-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0]  sram_addr,
  output logic [DATA_WIDTH-1:0]  sram_din,
  input  logic [DATA_WIDTH-1:0]  sram_dout
);

  localparam int CW = $clog2(RSP_DEPTH + 1);

  sram_req_t     req;
  sram_rsp_t     rsp_new, fifo_head, rsp_out;
  logic          run_q;
  logic          inflight_q, inflight_d;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   occ;
  logic          credit_ok, fire, rsp_take;
  logic          fifo_empty, fifo_push, fifo_pop;

  assign req = '{we: req_we, wmask: req_wmask, addr: req_addr, wdata: req_wdata};

  // Outstanding responses: queued plus the one the macro is reading this cycle.
  assign occ       = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
  assign credit_ok = (occ < (CW+1)'(RSP_DEPTH));
  assign fire      = req_valid & req_ready;

`ifdef SRAM_REQ_ADAPTER_WRITE_ACK_EN
  logic inflight_wr_q;

  assign req_ready = run_q & credit_ok;
  assign rsp_take  = fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inflight_wr_q <= 1'b0;
    else        inflight_wr_q <= fire & req.we;
  end

  // Macro output is garbage after a write, so an ack carries zero data.
  assign rsp_new.is_wr = inflight_wr_q;
  assign rsp_new.rdata = inflight_wr_q ? '0 : sram_dout;
`else
  assign req_ready = run_q & (req.we | credit_ok);
  assign rsp_take  = fire & ~req.we;
  assign rsp_new   = '{is_wr: 1'b0, rdata: sram_dout};
`endif

  assign inflight_d = rsp_take;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q      <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      run_q      <= 1'b1;
      inflight_q <= inflight_d;
    end
  end

  // Non-accepted writes must never reach the array.
  assign sram_we    = fire & req.we;
  assign sram_wmask = sram_we ? req.wmask : '0;
  assign sram_addr  = req.addr;
  assign sram_din   = req.wdata;

  // Empty FIFO: macro data bypasses straight out; otherwise it queues behind older beats.
  assign fifo_push = inflight_q & (~fifo_empty | ~rsp_ready);
  assign fifo_pop  = ~fifo_empty & rsp_ready;

  sram_rsp_fifo #(
    .WIDTH ($bits(sram_rsp_t)),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (rsp_new),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  assign rsp_out   = fifo_empty ? rsp_new : fifo_head;
  assign rsp_valid = inflight_q | ~fifo_empty;
  assign rsp_rdata = rsp_valid ? rsp_out.rdata : '0;
  assign rsp_is_wr = rsp_valid & rsp_out.is_wr;

endmodule

// File: tb/tb_sram_req_adapter.sv
// Randomized and directed bench for sram_req_adapter against a queue-based response model.
module tb_sram_req_adapter;

  localparam int DW = 32;
  localparam int AW = 6;
  localparam int MW = 4;
  localparam int D  = 2;
`ifdef SRAM_REQ_ADAPTER_WRITE_ACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [MW-1:0] req_wmask = '0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_ready = 1'b0;
  logic          req_ready, rsp_valid, rsp_is_wr, sram_we;
  logic [DW-1:0] rsp_rdata, sram_din, sram_dout;
  logic [MW-1:0] sram_wmask;
  logic [AW-1:0] sram_addr;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  sram_req_adapter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_wmask (req_wmask),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_is_wr (rsp_is_wr),
    .sram_we   (sram_we),
    .sram_wmask(sram_wmask),
    .sram_addr (sram_addr),
    .sram_din  (sram_din),
    .sram_dout (sram_dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Macro model: registered read every cycle, garbage on dout after a write.
  logic [DW-1:0] mac_mem [64] = '{default: '0};
  always @(posedge clk) begin
    if (sram_we) begin
      for (int b = 0; b < MW; b++)
        if (sram_wmask[b]) mac_mem[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
      sram_dout <= $urandom();
    end else begin
      sram_dout <= mac_mem[sram_addr];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: memory image plus queue of responses owed, in acceptance order.
  logic [DW-1:0] ref_mem [64];
  logic [DW:0]   exp_q [$];
  logic [DW-1:0] got_q [$];
  int            got_t [$];
  logic [DW:0]   all_q [$];
  bit            m_run = 1'b0;
  bit            fire, e_ready;

  initial forever begin
    @(posedge clk or negedge rst_n);
    m_run = rst_n;
  end

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_sram_we",   sram_we,   0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_is_wr", rsp_is_wr, 0);
      end else begin
        e_ready = m_run && ((req_we && !ACK) || exp_q.size() < D);
        chk("req_ready", req_ready, e_ready);
        chk("rsp_valid", rsp_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
          chk("rsp_rdata", rsp_rdata, exp_q[0][DW-1:0]);
          chk("rsp_is_wr", rsp_is_wr, exp_q[0][DW]);
        end
        fire = req_valid && req_ready;
        chk("sram_we",    sram_we,    fire && req_we);
        chk("sram_wmask", sram_wmask, (fire && req_we) ? req_wmask : '0);
        chk("sram_addr",  sram_addr,  req_addr);
        chk("sram_din",   sram_din,   req_wdata);
        if (rsp_valid && rsp_ready && exp_q.size() != 0) begin
          all_q.push_back({rsp_is_wr, rsp_rdata});
          if (!exp_q[0][DW]) begin
            got_q.push_back(rsp_rdata);
            got_t.push_back(cyc);
          end
          void'(exp_q.pop_front());
        end
        if (fire) begin
          if (req_we) begin
            for (int b = 0; b < MW; b++)
              if (req_wmask[b]) ref_mem[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
            if (ACK) exp_q.push_back({1'b1, {DW{1'b0}}});
          end else begin
            exp_q.push_back({1'b0, ref_mem[req_addr]});
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = 1'b0;
  endtask

  // Holds the request until accepted; returns wait cycles and the acceptance cycle.
  task automatic send(input bit we, input logic [MW-1:0] m, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, output int waited, output int acc_cyc);
    bit acc = 1'b0;
    waited = 0;
    acc_cyc = 0;
    req_valid = 1'b1; req_we = we; req_wmask = m; req_addr = a; req_wdata = d;
    while (!acc && waited < 200) begin
      @(negedge clk);
      acc = req_ready;
      acc_cyc = cyc;
      step();
      waited++;
    end
    chk("req_accepted", acc, 1);
  endtask

  task automatic drain();
    int k = 0;
    idle();
    rsp_ready = 1'b1;
    while (exp_q.size() != 0 && k < 100) begin step(); k++; end
    step();
    chk("drain_empty", exp_q.size(), 0);
  endtask

  int w, ac, accepted;

  initial begin
    // Reset held with a pending request
    #1 rst_n = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = '0; rsp_ready = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    send(0, '0, 0, '0, w, ac);
    idle();
    chk("first_read_wait", w, 2);
    drain();

    // Masked write over zeros, then read back
    got_q.delete(); got_t.delete();
    send(1, 4'b0101, 5, 32'hAABBCCDD, w, ac);
    send(0, '0, 5, '0, w, ac);
    idle();
    drain();
    chk("wr_rd_count", got_q.size(), 1);
    if (got_q.size() == 1) begin
      chk("wr_rd_data",    got_q[0], 32'h00BB00DD);
      chk("wr_rd_latency", got_t[0] - ac, 1);
    end

    // Preload 0..15 with addr*3, then stream reads
    for (int i = 0; i < 16; i++) send(1, 4'hF, AW'(i), DW'(i * 3), w, ac);
    got_q.delete(); got_t.delete();
    for (int i = 0; i < 16; i++) begin
      send(0, '0, AW'(i), '0, w, ac);
      chk("stream_rate", w, 1);
    end
    drain();
    chk("stream_count", got_q.size(), 16);
    if (got_q.size() == 16)
      for (int i = 0; i < 16; i++) begin
        chk("stream_data", got_q[i], DW'(i * 3));
        chk("stream_gap",  got_t[i] - got_t[0], i);
      end

    // Backpressure: only RSP_DEPTH reads may be outstanding
    got_q.delete();
    rsp_ready = 1'b0;
    accepted = 0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (req_ready) accepted++;
      step();
      req_addr = AW'(accepted);
    end
    chk("bp_accepted", accepted, 2);
    chk("bp_ready_low", req_ready, 0);
    rsp_ready = 1'b1;
    for (int i = 2; i < 4; i++) send(0, '0, AW'(i), '0, w, ac);
    drain();
    chk("bp_count", got_q.size(), 4);
    if (got_q.size() == 4)
      for (int i = 0; i < 4; i++) chk("bp_order", got_q[i], DW'(i * 3));

    // Reset with one beat queued and one in flight
    rsp_ready = 1'b0;
    send(0, '0, 7, '0, w, ac);
    send(0, '0, 8, '0, w, ac);
    idle();
    chk("mid_pre_valid", rsp_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", rsp_valid, 0);
    step(); step();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    got_q.delete(); all_q.delete();
    repeat (6) step();
    chk("no_stale_beats", all_q.size(), 0);

`ifdef SRAM_REQ_ADAPTER_WRITE_ACK_EN
    all_q.delete();
    send(1, 4'hF, 40, 32'h12345678, w, ac);
    send(0, '0, 40, '0, w, ac);
    drain();
    chk("ack_count", all_q.size(), 2);
    if (all_q.size() == 2) begin
      chk("ack_beat0", all_q[0], {1'b1, 32'h0});
      chk("ack_beat1", all_q[1], {1'b0, 32'h12345678});
    end
`endif

    // Random traffic checked cycle by cycle against the model
    for (int c = 0; c < 1500; c++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_we    = $urandom_range(0, 2) == 0;
      req_wmask = MW'($urandom_range(0, 15));
      req_addr  = AW'($urandom_range(0, 63));
      req_wdata = $urandom();
      rsp_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
